// File: rtl/dii_packet_arbiter_pkg.sv
// Shared types for the dii packet arbiter: flit payload and arbiter FSM states.
package dii_packet_arbiter_pkg;

  localparam int unsigned DII_DATA_W = 16;

  typedef struct packed {
    logic                  valid;
    logic                  last;
    logic [DII_DATA_W-1:0] data;
  } dii_flit;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_e;

endpackage

// File: rtl/dii_packet_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first unmasked requester at or after ptr,
// wrapping modulo N.
module dii_rr_arbiter #(
  parameter int unsigned N = 4,
  localparam int unsigned PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [N-1:0]  mask,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt_onehot,
  output logic          gnt_valid
);

  logic [N-1:0] cand;
  int unsigned  pos;

  always_comb begin
    gnt_onehot = '0;
    gnt_valid  = 1'b0;
    cand       = req & ~mask;
    pos        = 0;
    for (int unsigned k = 0; k < N; k++) begin
      pos = 32'(ptr) + k;
      if (pos >= N) pos = pos - N;
      if (!gnt_valid && cand[PW'(pos)]) begin
        gnt_onehot[PW'(pos)] = 1'b1;
        gnt_valid            = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dii_packet_arbiter.sv
// Packet-level round-robin merge of N dii_flit streams; grant held until last flit.
// Optional per-port completed-packet counters under DII_ARB_STATS_EN.
module dii_packet_arbiter
  import dii_packet_arbiter_pkg::*;
#(
  parameter int unsigned N = 4
`ifdef DII_ARB_STATS_EN
  , parameter int unsigned CNT_WIDTH = 16
`endif
) (
  input  logic                        clk,
  input  logic                        rst,
  input  dii_flit [N-1:0]             flit_in,
  output logic [N-1:0]                flit_in_ready,
  output dii_flit                     flit_out,
  input  logic                        flit_out_ready,
  output logic [N-1:0]                grant,
  output logic                        busy
`ifdef DII_ARB_STATS_EN
  , output logic [N-1:0][CNT_WIDTH-1:0] pkt_count
`endif
);

  localparam int unsigned PW = $clog2(N);

  arb_state_e    state_q, state_d;
  logic [N-1:0]  grant_q, grant_d;
  logic          busy_q, busy_d;
  logic [PW-1:0] rr_ptr_q, rr_ptr_d;

  logic [PW-1:0] gidx, gidx_next;
  logic [N-1:0]  req, arb_mask, arb_gnt;
  logic [PW-1:0] arb_ptr;
  logic          arb_valid;
  logic          xfer_last;

  // Index of the held grant and the port after it.
  always_comb begin
    gidx = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (grant_q[i]) gidx = PW'(i);
    end
    gidx_next = (gidx == PW'(N - 1)) ? '0 : gidx + PW'(1);
  end

  always_comb begin
    flit_out      = '0;
    flit_in_ready = '0;
    req           = '0;
    for (int unsigned i = 0; i < N; i++) req[i] = flit_in[i].valid;
    if (state_q == ST_BUSY) begin
      flit_out            = flit_in[gidx];
      flit_in_ready[gidx] = flit_out_ready;
    end
    xfer_last = (state_q == ST_BUSY) & flit_out.valid & flit_out_ready & flit_out.last;
  end

  // Handover masks the finishing port and searches from the port after it.
  always_comb begin
    arb_mask = (state_q == ST_BUSY) ? grant_q : '0;
    arb_ptr  = (state_q == ST_BUSY) ? gidx_next : rr_ptr_q;
  end

  dii_rr_arbiter #(.N(N)) u_rr (
    .req       (req),
    .mask      (arb_mask),
    .ptr       (arb_ptr),
    .gnt_onehot(arb_gnt),
    .gnt_valid (arb_valid)
  );

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          grant_d = arb_gnt;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (xfer_last) begin
          rr_ptr_d = gidx_next;
          if (arb_valid) begin
            grant_d = arb_gnt;
          end else begin
            grant_d = '0;
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
    busy_d = (state_d == ST_BUSY);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      busy_q   <= 1'b0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      busy_q   <= busy_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign grant = grant_q;
  assign busy  = busy_q;

`ifdef DII_ARB_STATS_EN
  logic [N-1:0][CNT_WIDTH-1:0] cnt_q, cnt_d;

  // Saturating count of completed packets per port.
  always_comb begin
    cnt_d = cnt_q;
    if (xfer_last && (cnt_q[gidx] != '1)) cnt_d[gidx] = cnt_q[gidx] + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign pkt_count = cnt_q;
`endif

endmodule
